// File: rtl/xbar_pkg.sv
// xbar_pkg: shared types and helpers for the stream crossbar
package xbar_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic {IDLE, LOCK} state_t;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
    logic                      id;
  } beat_t;
  // Same encoding as par_coder: lowest set bit wins on a non-one-hot vector.
  function automatic int unsigned onehot_to_idx(input logic [31:0] v);
    onehot_to_idx = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) onehot_to_idx = i;
  endfunction
endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: two-entry register slice with fully registered outputs
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             push;
  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid  <= skid_valid || push;
      if (skid_valid || push) out_data <= skid_valid ? skid_data : in_data;
      skid_valid <= 1'b0;
    end else if (push) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/stream_out_mux.sv
// stream_out_mux: locks an arbiter grant for a whole packet and routes it to one output
module stream_out_mux
  import xbar_pkg::*;
#(
  parameter int NUM_REQUEST = 2,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  localparam int ID_WIDTH   = $clog2(NUM_REQUEST)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_REQUEST-1:0]            s_valid_i,
  input  logic [NUM_REQUEST-1:0]            s_last_i,
  output logic [NUM_REQUEST-1:0]            s_ready_o,
  input  logic [NUM_REQUEST-1:0]            grant_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic                              m_valid_o,
  output logic                              m_last_o,
  output logic [ID_WIDTH-1:0]               m_id_o,
  input  logic                              m_ready_i,
  output logic                              pkt_done_o
);
  localparam int PW = DATA_WIDTH + 1 + ID_WIDTH;
  state_t              state, state_d;
  logic [ID_WIDTH-1:0] sel, sel_d;
  logic                buf_ready, accept, accept_last;
  logic [PW-1:0]       buf_out;
  assign accept      = s_valid_i[sel] && s_ready_o[sel];
  assign accept_last = accept && s_last_i[sel];
  always_comb begin
    state_d   = state;
    sel_d     = sel;
    s_ready_o = (state == LOCK && buf_ready) ? NUM_REQUEST'(1) << sel : '0;
    if (state == IDLE && |grant_i) begin
      state_d = LOCK;
      sel_d   = ID_WIDTH'(onehot_to_idx(32'(grant_i)));
    end
    if (state == LOCK && accept_last) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      pkt_done_o <= 1'b0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      pkt_done_o <= accept_last;
    end
  end
  stream_skid_buffer #(.WIDTH(PW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({s_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH], s_last_i[sel], sel}),
    .in_valid (accept),
    .in_ready (buf_ready),
    .out_data (buf_out),
    .out_valid(m_valid_o),
    .out_ready(m_ready_i)
  );
  assign {m_data_o, m_last_o, m_id_o} = buf_out;
endmodule

// File: tb/tb_stream_out_mux.sv
// tb_stream_out_mux: directed vector table, corner sequences and a random soak
module tb_stream_out_mux;
  import xbar_pkg::*;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2*DW-1:0] s_data_i = '0;
  logic [1:0]    s_valid_i = '0, s_last_i = '0, grant_i = '0, s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o, m_last_o, m_ready_i = 1'b1, pkt_done_o;
  logic [0:0]    m_id_o;
  int            checks = 0, bad = 0;
  beat_t         q[$];
  typedef struct {
    logic [1:0] grant, valid, last;
    logic [31:0] d0, d1;
    logic mr;
    logic [1:0] e_rdy;
    logic e_mv;
    logic [31:0] e_md;
    logic e_ml, e_id, e_pd;
  } vec_t;
  vec_t tbl[15];
  always #5 clk = ~clk;
  stream_out_mux #(.NUM_REQUEST(2), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .s_ready_o(s_ready_o), .grant_i(grant_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_id_o(m_id_o), .m_ready_i(m_ready_i), .pkt_done_o(pkt_done_o)
  );
  always @(negedge clk) begin
    beat_t b;
    b.data = m_data_o;
    b.last = m_last_o;
    b.id   = m_id_o[0];
    if (m_valid_o && m_ready_i) q.push_back(b);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input int src, input logic [31:0] d, input logic l);
    int n = 0;
    s_valid_i[src] = 1'b1;
    s_data_i[src*DW +: DW] = d;
    s_last_i[src] = l;
    @(negedge clk);
    while (!s_ready_o[src] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) begin
      checks++;
      bad++;
      $display("FAIL send_timeout: src %0d ready never seen, want handshake", src);
    end
    step();
  endtask
  task automatic chk_q(input string name, input logic [31:0] base, input int n, input logic id);
    chk({name, "_count"}, q.size(), n);
    for (int k = 0; k < n && k < q.size(); k++) begin
      chk({name, "_data"}, q[k].data, base + k);
      chk({name, "_last"}, 32'(q[k].last), 32'(k == n - 1));
      chk({name, "_id"}, 32'(q[k].id), 32'(id));
    end
  endtask
  function automatic logic is_last(input int src, input int s);
    return src == 0 ? (s % 4 == 3) : (s % 3 == 2);
  endfunction
  initial begin
    int seq[2];
    int nxt[2];
    int sent, sid;
    logic [1:0] acc;
    logic open, open_id;
    tbl[0]  = '{2'b01, 2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 2'b01, 2'b00, 32'hA0, 32'h0,  1'b1, 2'b01, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b00, 2'b01, 2'b00, 32'hA1, 32'h0,  1'b1, 2'b01, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 2'b01, 2'b00, 32'hA2, 32'h0,  1'b1, 2'b01, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b00, 2'b01, 2'b01, 32'hA3, 32'h0,  1'b1, 2'b01, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{2'b10, 2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 2'b11, 2'b00, 32'hC0, 32'hB0, 1'b1, 2'b10, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'b01, 2'b11, 2'b00, 32'hC0, 32'hB1, 1'b1, 2'b10, 1'b1, 32'hB1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{2'b01, 2'b11, 2'b10, 32'hC0, 32'hB2, 1'b1, 2'b10, 1'b1, 32'hB2, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{2'b01, 2'b01, 2'b00, 32'hC0, 32'h0,  1'b1, 2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 2'b01, 2'b00, 32'hC0, 32'h0,  1'b1, 2'b01, 1'b1, 32'hC0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 2'b01, 2'b01, 32'hC1, 32'h0,  1'b1, 2'b01, 1'b1, 32'hC1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{2'b11, 2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{2'b00, 2'b11, 2'b11, 32'hD0, 32'hE0, 1'b1, 2'b01, 1'b1, 32'hD0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", s_ready_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_id", m_id_o, 0);
    chk("rst_done", pkt_done_o, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 15; r++) begin
      grant_i   = tbl[r].grant;
      s_valid_i = tbl[r].valid;
      s_last_i  = tbl[r].last;
      s_data_i  = {tbl[r].d1, tbl[r].d0};
      m_ready_i = tbl[r].mr;
      #1;
      chk($sformatf("vec%0d_ready", r), s_ready_o, tbl[r].e_rdy);
      step();
      chk($sformatf("vec%0d_valid", r), m_valid_o, tbl[r].e_mv);
      if (tbl[r].e_mv) begin
        chk($sformatf("vec%0d_data", r), m_data_o, tbl[r].e_md);
        chk($sformatf("vec%0d_last", r), m_last_o, tbl[r].e_ml);
        chk($sformatf("vec%0d_id", r), m_id_o, tbl[r].e_id);
      end
      chk($sformatf("vec%0d_done", r), pkt_done_o, tbl[r].e_pd);
    end
    // backpressure: two beats fill the buffer, then the input must stall
    q.delete();
    m_ready_i = 1'b0;
    grant_i = 2'b01;
    step();
    grant_i = 2'b00;
    s_valid_i = 2'b01;
    s_last_i = 2'b00;
    s_data_i[DW-1:0] = 32'hF0;
    step();
    s_data_i[DW-1:0] = 32'hF1;
    step();
    s_data_i[DW-1:0] = 32'hF2;
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready", s_ready_o, 0);
      chk("bp_valid", m_valid_o, 1);
      chk("bp_hold_data", m_data_o, 32'hF0);
      chk("bp_hold_last", m_last_o, 0);
      step();
    end
    m_ready_i = 1'b1;
    for (int k = 2; k < 6; k++) send_beat(0, 32'hF0 + k, k == 5);
    s_valid_i = '0;
    s_last_i = '0;
    repeat (4) step();
    chk_q("bp", 32'hF0, 6, 1'b0);
    // reset mid-packet: all outputs drop without a clock edge
    q.delete();
    grant_i = 2'b10;
    step();
    grant_i = 2'b00;
    send_beat(1, 32'h60, 1'b0);
    send_beat(1, 32'h61, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready_o, 0);
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_data", m_data_o, 0);
    chk("mid_rst_last", m_last_o, 0);
    chk("mid_rst_id", m_id_o, 0);
    chk("mid_rst_done", pkt_done_o, 0);
    s_valid_i = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    q.delete();
    grant_i = 2'b10;
    step();
    grant_i = 2'b00;
    for (int k = 0; k < 3; k++) send_beat(1, 32'h70 + k, k == 2);
    s_valid_i = '0;
    s_last_i = '0;
    repeat (3) step();
    chk_q("post_rst", 32'h70, 3, 1'b1);
    // random soak against per-source sequence model
    q.delete();
    seq = '{0, 0};
    sent = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = s_valid_i & s_ready_o;
      step();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          seq[i]++;
          sent++;
        end
        if (!s_valid_i[i] || acc[i]) begin
          s_valid_i[i] = ($urandom_range(0, 3) != 0);
          s_data_i[i*DW +: DW] = {i[15:0], seq[i][15:0]};
          s_last_i[i] = is_last(i, seq[i]);
        end
      end
      grant_i = 2'($urandom_range(0, 3));
      m_ready_i = ($urandom_range(0, 3) != 0);
    end
    s_valid_i = '0;
    grant_i = '0;
    m_ready_i = 1'b1;
    repeat (6) step();
    chk("soak_count", q.size(), sent);
    nxt = '{0, 0};
    open = 1'b0;
    open_id = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      sid = int'(q[k].id);
      chk("soak_src", q[k].data[31:16], 32'(q[k].id));
      chk("soak_seq", q[k].data[15:0], nxt[sid]);
      chk("soak_last", 32'(q[k].last), 32'(is_last(sid, int'(q[k].data[15:0]))));
      if (open) chk("soak_interleave", 32'(q[k].id), 32'(open_id));
      nxt[sid] = int'(q[k].data[15:0]) + 1;
      open = !q[k].last;
      open_id = q[k].id;
    end
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule

// File: doc/stream_out_mux.md
Name: stream_out_mux

Overview:
Per-output-port packet multiplexer of the stream crossbar, directly downstream of the round-robin arbiter.
- Consumes the arbiter's one-hot grant vector and locks it for a whole packet, from first beat to the beat with last set.
- Routes the locked input's AXI-Stream-style beats to one output through a registered two-entry skid buffer.
- Reports a packet-done pulse and the source id of each beat.

Parameters:
- NUM_REQUEST, 2, number of input streams competing for this output; must be >= 2.
- DATA_WIDTH, 32, beat data width in bits.
- ID_WIDTH, $clog2(NUM_REQUEST), localparam; width of the source-id field.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset (asserts immediately, released synchronously by the integrator).
- s_data_i  in  NUM_REQUEST*DATA_WIDTH  input beats; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid_i  in  NUM_REQUEST  per-input valid.
- s_last_i  in  NUM_REQUEST  per-input end-of-packet marker.
- s_ready_o  out  NUM_REQUEST  per-input ready; at most one bit high in any cycle.
- grant_i  in  NUM_REQUEST  grant vector from the arbiter; one-hot or zero.
- m_data_o  out  DATA_WIDTH  output beat data.
- m_valid_o  out  1  output valid.
- m_last_o  out  1  output end-of-packet.
- m_id_o  out  ID_WIDTH  index of the input that produced the current output beat.
- m_ready_i  in  1  downstream ready.
- pkt_done_o  out  1  one-cycle pulse when a last beat is accepted from the locked input.

Behaviour:
- Reset values: s_ready_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=0, pkt_done_o=0. Both skid entries are empty and the FSM is in IDLE.
- FSM state IDLE: s_ready_o=0. If grant_i != 0, latch sel = index of grant_i; a non-one-hot grant resolves to the lowest set bit. Then go to LOCK. If grant_i == 0, stay in IDLE.
- FSM state LOCK: s_ready_o[sel] = skid buffer not full; all other s_ready_o bits are 0. grant_i is ignored while in LOCK.
- Beat acceptance: a beat is accepted when s_valid_i[sel] && s_ready_o[sel]. It is written into the skid buffer with {data, last, sel}.
- Leaving LOCK: an accepted beat with s_last_i[sel]=1 returns the FSM to IDLE and pulses pkt_done_o on the next cycle.
- Re-lock latency: the earliest next lock is the cycle after returning to IDLE, giving one dead input cycle between packets.
- Skid buffer: two entries, registered outputs, no combinational path from m_ready_i to s_ready_o.
  - Input-to-output latency is one cycle: a beat accepted at edge N appears on m_* after edge N.
  - Sustained throughput is one beat per cycle while m_ready_i=1.
  - When m_ready_i=0, the buffer holds at most 2 beats. s_ready_o deasserts one cycle after the buffer becomes full.
- Output stability: while m_valid_o=1 && m_ready_i=0, m_data_o, m_last_o and m_id_o hold stable.
- Ordering: beats leave in acceptance order. Data and last pass through unmodified.
- Simultaneous events: a new beat accepted in the same cycle the output drains keeps occupancy unchanged. A last beat accepted in the same cycle grant_i changes still returns to IDLE; the new grant is sampled in IDLE.
- Input dropping valid mid-packet: the FSM stays in LOCK indefinitely; no timeout.
- Reset mid-packet: all state clears asynchronously and buffered beats are discarded. After release, the block starts in IDLE.

Decomposition:
- Shared package xbar_pkg holds:
  - DATA_WIDTH default;
  - beat struct typedef {data, last, id};
  - FSM state enum {IDLE, LOCK};
  - one-hot-to-index function. This function is the same encoding par_coder performs; par_coder stays the single implementation for netlists.
- Sub-module stream_skid_buffer: 2-entry register slice, parameterised by payload width; reusable on crossbar inputs.
- Top level holds the lock FSM, input mux and ready decode.

Test Plan:
- Single packet: grant_i=2'b01 then s_valid_i[0] with 4 beats 0xA0..0xA3, last on 0xA3, m_ready_i=1 -> m_data_o shows 0xA0..0xA3 on consecutive cycles, each one cycle after acceptance; m_id_o=0; m_last_o on 0xA3; pkt_done_o pulses once.
- Lock hold: grant_i switches 2'b10 -> 2'b01 mid-packet of input 1 (3 beats 0xB0..0xB2) -> all 3 beats have m_id_o=1; input 0 sees s_ready_o[0]=0 throughout; input 0's packet follows after one dead cycle.
- Backpressure: m_ready_i=0 for 5 cycles during a 6-beat packet -> exactly 2 beats buffered, s_ready_o drops; output holds stable; no loss or duplication after m_ready_i returns to 1.
- Malformed grant: grant_i=2'b11 -> input 0 selected, m_id_o=0.
- Reset mid-packet: assert rst_n=0 after beat 2 of 4 -> all outputs are 0 immediately, even without a clock edge. After release, a fresh packet from grant_i=2'b10 passes correctly.
- Random soak: random valid/ready/grant over 10k cycles checked against a reference queue model -> beat order, last and id all match; no beat interleaving within a packet.
